// File: rtl/alu_rr_sequencer_ody.sv
// Round-robin sequencer sharing one external signed ALU between two requesters.
// Optional grant counters are enabled by defining ALU_SEQ_STATS_EN.
module alu_rr_sequencer_ody #(
  parameter int unsigned N = 3,
  localparam int unsigned OW = N + 1,
  localparam int unsigned RW = N + 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic signed [OW-1:0] req0_x,
  input  logic signed [OW-1:0] req0_y,
  input  logic [2:0]           req0_s,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic signed [OW-1:0] req1_x,
  input  logic signed [OW-1:0] req1_y,
  input  logic [2:0]           req1_s,
  output logic signed [OW-1:0] alu_x,
  output logic signed [OW-1:0] alu_y,
  output logic [2:0]           alu_s,
  input  logic signed [RW-1:0] alu_o,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [RW-1:0] res_data,
  output logic                 res_id,
`ifdef ALU_SEQ_STATS_EN
  output logic [7:0]           gnt0_cnt,
  output logic [7:0]           gnt1_cnt,
`endif
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   grant_id;
  logic   grant_vld;
  logic   accept;

  // Tie goes to the requester that did not win last time.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          accept     = 1'b1;
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          state_nxt  = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, result capture and status flags; alu_* hold between ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_x      <= '0;
      alu_y      <= '0;
      alu_s      <= 3'b000;
      res_data   <= '0;
      res_id     <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        alu_x      <= grant_id ? req1_x : req0_x;
        alu_y      <= grant_id ? req1_y : req0_y;
        alu_s      <= grant_id ? req1_s : req0_s;
        res_id     <= grant_id;
        last_grant <= grant_id;
      end
      if (state == EXEC) res_data <= alu_o;
      res_valid <= (state_nxt == RESP);
      busy      <= (state_nxt != IDLE);
    end
  end

`ifdef ALU_SEQ_STATS_EN
  // Free-running 8-bit accept counters, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_cnt <= 8'd0;
      gnt1_cnt <= 8'd0;
    end else if (accept) begin
      if (grant_id) gnt1_cnt <= gnt1_cnt + 8'd1;
      else          gnt0_cnt <= gnt0_cnt + 8'd1;
    end
  end
`endif

endmodule
